// File: rtl/rv_data_out_bfm.sv
// rv_data_out_bfm: ready/valid source BFM. Host pushes beats into a small FIFO;
// an output stage presents them to the sink with full ready/valid rules.
// Optional inter-beat gap throttling is compiled in with RV_DATA_OUT_BFM_GAP_EN.
module rv_data_out_bfm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   data_valid,
    input  logic                   data_ready,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [GAP_WIDTH-1:0]   gap,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            xfer_count,
    output logic                   idle
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

`ifdef RV_DATA_OUT_BFM_GAP_EN
    typedef enum logic [1:0] {StEmpty, StPresent, StGap} state_e;
`else
    typedef enum logic {StEmpty, StPresent} state_e;
`endif

    state_e                state_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  push_ready_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [31:0]           xfer_q;

    logic push_acc;
    logic handshake;
    logic have_beat;
    logic pop;
    logic start_gap;
    logic gap_last;

`ifdef RV_DATA_OUT_BFM_GAP_EN
    logic [GAP_WIDTH-1:0] gap_cnt_q;
    assign start_gap = (gap != '0);
    assign gap_last  = (gap_cnt_q == GAP_WIDTH'(1));
`else
    // gap port kept for interface compatibility but has no effect
    logic unused_gap;
    assign unused_gap = ^gap;
    assign start_gap  = 1'b0;
    assign gap_last   = 1'b0;
`endif

    // Decode enqueue/dequeue for this edge and the resulting occupancy
    always_comb begin
        push_acc  = push_valid && push_ready_q;
        handshake = valid_q && data_ready;
        have_beat = (level_q != '0);
        pop       = 1'b0;
        case (state_q)
            StEmpty:   pop = have_beat;
            StPresent: pop = handshake && !start_gap && have_beat;
`ifdef RV_DATA_OUT_BFM_GAP_EN
            StGap:     pop = gap_last && have_beat;
`endif
            default:   pop = 1'b0;
        endcase
        level_d = level_q + {{PtrW{1'b0}}, push_acc} - {{PtrW{1'b0}}, pop};
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers, occupancy and registered push_ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            push_ready_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q      <= level_d;
            push_ready_q <= (level_d != Full);
        end
    end

    // Output stage FSM with registered data/valid and transfer counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StEmpty;
            data_q    <= '0;
            valid_q   <= 1'b0;
            xfer_q    <= '0;
`ifdef RV_DATA_OUT_BFM_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                StEmpty: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        valid_q <= 1'b1;
                        state_q <= StPresent;
                    end
                end
                StPresent: begin
                    if (handshake) begin
                        xfer_q <= xfer_q + 32'd1;
                        if (start_gap) begin
`ifdef RV_DATA_OUT_BFM_GAP_EN
                            gap_cnt_q <= gap;
                            valid_q   <= 1'b0;
                            state_q   <= StGap;
`endif
                        end else if (pop) begin
                            data_q <= mem_q[rd_ptr_q];
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= StEmpty;
                        end
                    end
                end
`ifdef RV_DATA_OUT_BFM_GAP_EN
                StGap: begin
                    gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
                    if (gap_last) begin
                        if (pop) begin
                            data_q  <= mem_q[rd_ptr_q];
                            valid_q <= 1'b1;
                            state_q <= StPresent;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign push_ready = push_ready_q;
    assign level      = level_q;
    assign xfer_count = xfer_q;
    assign idle       = (level_q == '0) && !valid_q;

endmodule

// File: doc/rv_data_out_bfm.md
# rv_data_out_bfm

Ready/valid source (transmitter) BFM that drives the `data`/`data_valid`/`data_ready` handshake toward a device under test. It is the counterpart of the ready/valid data-in (receiver) BFM. A host-side push port queues beats into an internal FIFO, and an output stage presents them to the sink under full protocol rules. An optional inter-beat gap throttles the source for stress testing.

## Interface
- `DATA_WIDTH`, 8, width of transferred data
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `GAP_WIDTH`, 8, width of the `gap` control
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `data`  out  DATA_WIDTH  beat presented to sink
- `data_valid`  out  1  beat on `data` is valid
- `data_ready`  in  1  sink accepts beat
- `push_data`  in  DATA_WIDTH  host beat to enqueue
- `push_valid`  in  1  host enqueue request
- `push_ready`  out  1  FIFO can accept; `level != DEPTH` and not in reset
- `gap`  in  GAP_WIDTH  idle cycles forced after each completed beat
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage
- `xfer_count`  out  32  completed handshakes; wraps modulo 2^32
- `idle`  out  1  FIFO empty and `data_valid` low

## Operation
- Enqueue occurs on an edge with `push_valid && push_ready`.
- A handshake is an edge with `data_valid && data_ready`. `data_ready` is ignored while `data_valid` is low.
- Output stage FSM:
  - EMPTY: `data_valid`=0. If `level>0`, pop the head into `data` and go to PRESENT.
  - PRESENT: `data_valid`=1. `data` is held stable until the handshake. On handshake:
    - `xfer_count`+1.
    - If effective gap G>0, load the gap counter with G and go to GAP.
    - Else, if `level>0`, pop the next head and stay in PRESENT (back-to-back beats, one per cycle).
    - Else, go to EMPTY.
  - GAP: `data_valid`=0 and the counter decrements each edge. On the edge where the counter is 1: pop the head and go to PRESENT if `level>0`, else go to EMPTY. This yields exactly G low cycles.
- `gap` is sampled at the handshake edge. Later changes do not affect a gap already in progress.
- Simultaneous push and pop: `level` is unchanged, and FIFO order is preserved.
- A push into an empty FIFO in EMPTY state is written on that edge and popped on the next edge. There is no bypass.
- When full, `push_ready` is low. A slot freed by a pop is visible on the next cycle.
- Pointers wrap modulo DEPTH. `level` distinguishes full from empty.
- Beats leave the BFM in push order.

## Timing
- Reset values (asserted immediately, asynchronously):
  - `data_valid`=0, `data`=0
  - `level`=0, `xfer_count`=0, `idle`=1
  - `push_ready`=0 while `reset` is high; 1 from the first cycle after release
  - FSM=EMPTY, gap counter=0
- Reset mid-operation discards all queued beats and the presented beat. No handshake completes on the reset edge.
- Latency: push accepted at edge t gives `data_valid` high after edge t+1 (FIFO empty, FSM EMPTY).
- Throughput: 1 beat/cycle with `gap`=0 and `data_ready` held high.
- `push_ready`, `data`, `data_valid`, `level`, `idle` and `xfer_count` are registered or derived only from registers. There is no combinational path from `data_ready` or `push_valid` to any output.

## Configuration
- Macro: `RV_DATA_OUT_BFM_GAP_EN`.
- Defined: gap counter and GAP state are compiled in, and the effective gap equals `gap`.
- Undefined: the GAP state and counter are absent. The `gap` port remains but is ignored (effective gap 0), and PRESENT transitions directly as for G=0.

## Test plan
- Reset: assert `reset` mid-cycle → `data_valid`=0, `data`=0, `level`=0, `xfer_count`=0, `idle`=1, `push_ready`=0. After release, `push_ready`=1.
- Single beat: push 0xA5 with `data_ready`=1 → `data`=0xA5 with `data_valid` high for exactly 1 cycle, beginning the cycle after the push-accept edge plus one. Then `xfer_count`=1 and `idle`=1.
- Fill/backpressure, DEPTH=4, `data_ready`=0: push 0x01..0x06 continuously → 0x01..0x05 are accepted (0x01 in the output stage, `level`=4) and `push_ready` drops with 0x06 stalled. Raise `data_ready` → 0x01..0x06 emerge in order, with `data_valid` continuously high for 6 cycles.
- Stability: randomly toggle `data_ready` over 100 queued beats → `data` never changes while `data_valid && !data_ready`. Output order matches push order and `xfer_count`=100.
- Gap (macro defined): `gap`=3, queue 3 beats, `data_ready`=1 → `data_valid` pattern is 1,0,0,0,1,0,0,0,1. With the macro undefined, the same stimulus gives 1,1,1.
- Reset mid-operation: with `level`=3 and a beat presented, assert `reset` → `data_valid` falls the same cycle. After release, `level`=0 and `xfer_count`=0, and no stale beat appears.
